// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch port with a fixed-latency read pipeline and a response FIFO.
// Optional macro IMEM_ERR_CHECK_EN flags misaligned/out-of-range fetches with rsp_err and a NOP response.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0]   BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [CW-1:0] OUT_MAX    = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [31:0]   NOP_INSTR  = 32'h0000_0013;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_fifoInstr [FIFO_DEPTH];
  logic          r_fifoErr [FIFO_DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_fifoCount;
  logic [CW-1:0] r_outstanding;

  logic          w_accept;
  logic          w_pop;
  logic          w_pushValid;
  logic [31:0]   w_pushInstr;
  logic          w_pushErr;
  logic [31:0]   w_readInstr;
  logic          w_readErr;
  logic [AW-1:0] w_reqIdx;
  logic [AW-1:0] w_progIdx;
  logic          w_progOk;
  logic          w_unused;

  assign w_reqIdx  = req_addr[AW+1:2];
  assign w_progIdx = prog_addr[AW+1:2];
  assign w_progOk  = prog_we && (prog_addr < BYTE_LIMIT);

`ifdef IMEM_ERR_CHECK_EN
  assign w_readErr = (req_addr[1:0] != 2'b00) || (req_addr >= BYTE_LIMIT);
  assign w_unused  = ^prog_addr[1:0];
`else
  assign w_readErr = 1'b0;
  assign w_unused  = ^{prog_addr[1:0], req_addr[1:0], req_addr[31:AW+2]};
`endif

  assign w_readInstr = w_readErr ? NOP_INSTR : r_mem[w_reqIdx];

  // The outstanding limit covers both pipeline and FIFO, so the pipeline can never overrun the FIFO.
  assign req_ready = !rst && !prog_we && (r_outstanding < OUT_MAX);
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = !rst && (r_fifoCount != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_instr = rsp_valid ? r_fifoInstr[r_rdPtr] : '0;
  assign rsp_err   = rsp_valid && r_fifoErr[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_progOk) begin
      r_mem[w_progIdx] <= prog_data;
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign w_pushValid = w_accept;
      assign w_pushInstr = w_readInstr;
      assign w_pushErr   = w_readErr;
    end else begin : g_pipe
      // The FIFO write is the final latency stage, hence LATENCY-1 registers here.
      logic        r_pipeValid [LATENCY-1];
      logic [31:0] r_pipeInstr [LATENCY-1];
      logic        r_pipeErr   [LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            r_pipeValid[i] <= 1'b0;
          end
        end else begin
          r_pipeValid[0] <= w_accept;
          for (int i = 1; i < LATENCY - 1; i++) begin
            r_pipeValid[i] <= r_pipeValid[i-1];
          end
        end
        r_pipeInstr[0] <= w_readInstr;
        r_pipeErr[0]   <= w_readErr;
        for (int i = 1; i < LATENCY - 1; i++) begin
          r_pipeInstr[i] <= r_pipeInstr[i-1];
          r_pipeErr[i]   <= r_pipeErr[i-1];
        end
      end

      assign w_pushValid = r_pipeValid[LATENCY-2];
      assign w_pushInstr = r_pipeInstr[LATENCY-2];
      assign w_pushErr   = r_pipeErr[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
      r_fifoCount   <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_pushValid) begin
        r_fifoInstr[r_wrPtr] <= w_pushInstr;
        r_fifoErr[r_wrPtr]   <= w_pushErr;
        r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + PW'(1);
      end
      case ({w_pushValid, w_pop})
        2'b10:   r_fifoCount <= r_fifoCount + CW'(1);
        2'b01:   r_fifoCount <= r_fifoCount - CW'(1);
        default: r_fifoCount <= r_fifoCount;
      endcase
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder: a queue-based reference model predicts ready/valid/instr/err every cycle.
module tb_imem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int LATENCY     = 2;
  localparam int FIFO_DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        prog_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_instr;

  always #5 clk = ~clk;

  imem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY(LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          readyCycle;
  } rsp_t;

  // Model: every accepted request is one queue entry until popped; it becomes visible LATENCY edges after acceptance.
  rsp_t        rspQ[$];
  logic [31:0] mMem [DEPTH_WORDS];
  int          cycleNo = 0;
  int          testCount = 0;
  int          failCount = 0;
  logic        expReady, expValid, expErr;
  logic [31:0] expInstr;
  logic [34:0] expVec, obsVec;

  function automatic rsp_t modelRead(input logic [31:0] a, input int c);
    rsp_t r;
    r.readyCycle = c + LATENCY;
    r.instr = mMem[a[9:2]];
    r.err   = 1'b0;
`ifdef IMEM_ERR_CHECK_EN
    if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH_WORDS)) begin
      r.instr = 32'h0000_0013;
      r.err   = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    expReady = !rst && !prog_we && (rspQ.size() < FIFO_DEPTH);
    expValid = 1'b0;
    if (!rst && rspQ.size() > 0) begin
      if (rspQ[0].readyCycle <= cycleNo) expValid = 1'b1;
    end
    expInstr = expValid ? rspQ[0].instr : 32'h0;
    expErr   = expValid ? rspQ[0].err : 1'b0;
    expVec   = {expReady, expValid, expInstr, expErr};
    obsVec   = {req_ready, rsp_valid, rsp_instr, rsp_err};
    @(posedge clk);
    if (rst) begin
      rspQ.delete();
    end else begin
      if (expValid && rsp_ready) void'(rspQ.pop_front());
      if (req_valid && expReady) rspQ.push_back(modelRead(req_addr, cycleNo));
      if (prog_we && prog_addr < 32'(4 * DEPTH_WORDS)) mMem[prog_addr[9:2]] = prog_data;
    end
    cycleNo++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      testCount++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL reset_hold k=%0d got %h want %h", k, obsVec, expVec);
      end
    end
    rst = 1'b0;
    req_valid = 1'b0;
    tick();
    testCount++;
    if (obsVec !== 35'h4_0000_0000) begin
      failCount++;
      $display("[TB] FAIL reset_release got %h want %h", obsVec, 35'h4_0000_0000);
    end
  endtask

  task automatic test_program_fetch();
    logic [31:0] words [4];
    logic [31:0] got[$];
    int firstIdx = -1;
    int lastIdx = -1;
    words[0] = 32'h0050_0093; words[1] = 32'h0010_0113;
    words[2] = 32'h0020_81B3; words[3] = 32'h0000_006F;
    prog_we = 1'b1;
    for (int k = 0; k < DEPTH_WORDS + 4; k++) begin
      prog_addr = (k < DEPTH_WORDS) ? 32'(k) << 2 : 32'(k - DEPTH_WORDS) << 2;
      prog_data = (k < DEPTH_WORDS) ? $urandom : words[k - DEPTH_WORDS];
      tick();
      testCount++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL program k=%0d got %h want %h", k, obsVec, expVec);
      end
    end
    prog_we = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 4);
      req_addr  = 32'(k % 4) << 2;
      tick();
      testCount++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL fetch k=%0d got %h want %h", k, obsVec, expVec);
      end
      if (obsVec[33]) begin
        got.push_back(obsVec[32:1]);
        if (firstIdx < 0) firstIdx = k;
        lastIdx = k;
      end
    end
    testCount++;
    if (got.size() != 4 || got[0] !== words[0] || got[1] !== words[1] ||
        got[2] !== words[2] || got[3] !== words[3]) begin
      failCount++;
      $display("[TB] FAIL fetch_words got %0d words first %h want 4 words first %h", got.size(),
               (got.size() > 0) ? got[0] : 32'h0, words[0]);
    end
    testCount++;
    if (firstIdx != LATENCY || lastIdx != LATENCY + 3) begin
      failCount++;
      $display("[TB] FAIL fetch_timing got first=%0d last=%0d want first=%0d last=%0d",
               firstIdx, lastIdx, LATENCY, LATENCY + 3);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    logic r0, r1;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_addr = 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2;
      tick();
      testCount++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL backpressure k=%0d got %h want %h", k, obsVec, expVec);
      end
      if (obsVec[34]) accepted++;
    end
    testCount++;
    if (accepted != FIFO_DEPTH) begin
      failCount++;
      $display("[TB] FAIL bp_accepted got %0d want %0d", accepted, FIFO_DEPTH);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    r0 = obsVec[34];
    tick();
    r1 = obsVec[34];
    testCount++;
    if ({r0, r1} !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL bp_ready_return got %b want 01", {r0, r1});
    end
    for (int k = 0; k < 40 && rspQ.size() > 0; k++) begin
      tick();
      testCount++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL bp_drain k=%0d got %h want %h", k, obsVec, expVec);
      end
    end
  endtask

  task automatic test_prog_collision();
    logic [31:0] got[$];
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0;
    prog_we = 1'b1; prog_addr = 32'd20; prog_data = $urandom;
    tick();
    testCount++;
    if (obsVec[34] !== 1'b0 || obsVec !== expVec) begin
      failCount++;
      $display("[TB] FAIL collision_block got %h want %h", obsVec, expVec);
    end
    prog_we = 1'b0; req_addr = 32'd8;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin
        req_valid = 1'b0;
        prog_we = 1'b1; prog_addr = 32'd8; prog_data = 32'hDEAD_BEEF;
      end else if (k == 2) begin
        prog_we = 1'b0;
      end
      tick();
      testCount++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL collision k=%0d got %h want %h", k, obsVec, expVec);
      end
      if (obsVec[33]) got.push_back(obsVec[32:1]);
    end
    testCount++;
    if (got.size() != 1 || got[0] !== 32'h0020_81B3) begin
      failCount++;
      $display("[TB] FAIL collision_oldword got n=%0d w=%h want n=1 w=%h", got.size(),
               (got.size() > 0) ? got[0] : 32'h0, 32'h0020_81B3);
    end
  endtask

  task automatic test_error();
    logic [32:0] got[$];
    logic [32:0] want0, want1;
`ifdef IMEM_ERR_CHECK_EN
    want0 = {32'h0000_0013, 1'b1};
    want1 = {32'h0000_0013, 1'b1};
`else
    want0 = {32'h0010_0113, 1'b0};
    want1 = {32'h0050_0093, 1'b0};
`endif
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 2);
      req_addr  = (k == 0) ? 32'h0000_0006 : 32'h0000_0400;
      tick();
      testCount++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL error k=%0d got %h want %h", k, obsVec, expVec);
      end
      if (obsVec[33]) got.push_back(obsVec[32:0]);
    end
    testCount++;
    if (got.size() != 2 || got[0] !== want0 || got[1] !== want1) begin
      failCount++;
      $display("[TB] FAIL error_words got n=%0d %h want n=2 %h %h", got.size(),
               (got.size() > 0) ? got[0] : 33'h0, want0, want1);
    end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr = 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2;
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    testCount++;
    if (obsVec[33] !== 1'b0 || obsVec !== expVec) begin
      failCount++;
      $display("[TB] FAIL midreset_idle got %h want %h", obsVec, expVec);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (obsVec[33]) seen++;
    end
    testCount++;
    if (seen != 0) begin
      failCount++;
      $display("[TB] FAIL midreset_stale got %0d responses want 0", seen);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      prog_we   = ($urandom_range(0, 9) == 0);
      prog_addr = $urandom_range(0, 1100);
      prog_data = $urandom;
      req_valid = ($urandom_range(0, 9) < 7);
      req_addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1100))
                                              : 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2;
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
      testCount++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL random k=%0d got %h want %h", k, obsVec, expVec);
      end
    end
    prog_we = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && rspQ.size() > 0; k++) begin
      tick();
      testCount++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL random_drain k=%0d got %h want %h", k, obsVec, expVec);
      end
    end
    testCount++;
    if (rspQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL random_drain_bound got %0d left want 0", rspQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_program_fetch();
    test_backpressure();
    test_prog_collision();
    test_error();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleNo);
    $fatal(1, "[TB] watchdog");
  end

endmodule
